imem_seq: RTL and testbench
===========================

# imem_seq

Parametrised instruction memory and sequencer for a PE. It loads a program word-by-word into a simple-dual-port BRAM, then replays it on an explicit `start` for a programmable number of passes, with stall support and a completion pulse. It replaces the fixed-delay auto-trigger scheme with a handshake-driven controller, and sits between the array instruction broadcast bus and the PE decode stage.

## Interface
- `INST_WIDTH`, 36: instruction word width.
- `DEPTH`, 256: instruction slots; power of two.
- `ADDR_WIDTH`, $clog2(DEPTH): BRAM address width.
- `LOOP_WIDTH`, 8: width of the pass-count input.
- `RD_LAT`, 2: BRAM read latency; fixed by the HIGH_PERFORMANCE output register.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load_v` in 1: write `load_inst` at the next load slot.
- `load_inst` in INST_WIDTH: instruction to load.
- `prog_clr` in 1: clear the program length and `load_err` (IDLE only).
- `start` in 1: begin replay (IDLE only).
- `loop_cnt` in LOOP_WIDTH: number of passes minus 1; sampled with `start`.
- `stall` in 1: hold the PC; no new reads are issued.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: one-cycle pulse at the end of a replay.
- `inst_out_v` out 1: `inst_out` is valid.
- `inst_out` out INST_WIDTH: instruction; forced to 0 when `inst_out_v` is 0.
- `prog_len` out ADDR_WIDTH+1: number of loaded instructions (0..DEPTH).
- `load_err` out 1: sticky error flag for overflow or a load while busy.

## Operation
- States:
  - IDLE: load and clear are accepted.
  - RUN: reads are issued.
  - DRAIN: waits for in-flight reads to complete.
- Load (IDLE):
  - When `load_v`=1 and `prog_len`<DEPTH, write the word to BRAM at address `prog_len`, then increment `prog_len`.
  - When `prog_len`=DEPTH, drop the word and set `load_err`.
- `prog_clr` in IDLE sets `prog_len` to 0 and `load_err` to 0. BRAM contents are not touched.
  - `prog_clr` and `load_v` in the same cycle: clear wins and the word is dropped.
- `load_v` while `busy`: word dropped, `load_err` set. `prog_clr` while `busy` is ignored.
- Start (IDLE, `start`=1):
  - `load_v`=1 in the same cycle: the load wins and `start` is ignored.
  - `prog_len`=0: no reads; `done` pulses next cycle and the block stays in IDLE.
  - Otherwise: latch `passes_left`=`loop_cnt`, set `pc`=0, go to RUN.
- `start` while `busy` is ignored.
- RUN, on each cycle with `stall`=0:
  - Issue a BRAM read at `pc` and push a 1 into the valid pipeline.
  - If `pc`=`prog_len`-1:
    - `passes_left`=0: go to DRAIN.
    - Otherwise: decrement `passes_left` and set `pc`=0.
  - Otherwise: increment `pc`.
- RUN, on each cycle with `stall`=1: `pc` holds and a 0 is pushed into the valid pipeline. Reads already in flight still emerge, so downstream must absorb up to RD_LAT words after it raises `stall`.
- DRAIN: `stall` is ignored. The block waits until the valid pipeline is empty. `done` pulses together with the final `inst_out_v`, then the next state is IDLE.
- Reset, asynchronous:
  - State IDLE.
  - `pc`, `prog_len`, `passes_left`, and the valid pipeline cleared.
  - All outputs 0.
  - BRAM contents preserved.
  - Reset mid-RUN aborts the replay with no `done` pulse.

## Timing
- Read issued at edge t gives `inst_out_v`=1 in the cycle after edge t+RD_LAT.
- `start` sampled at edge 0:
  - First read issues at edge 1.
  - First `inst_out_v` appears after edge 3.
- No stalls, L instructions, P passes:
  - L·P consecutive valid cycles.
  - `done` coincident with the last valid cycle.
  - `busy` falls the following cycle.
- `busy` rises the cycle after the accepted `start`.
- A new `start` is accepted in the first IDLE cycle.
- `prog_len` updates the cycle after `load_v`.
- Back-to-back `load_v` writes every cycle.

## Structure
- `parameters.vh` holds the default INST_WIDTH, DEPTH, ADDR_WIDTH and LOOP_WIDTH, plus the state encodings (IDLE/RUN/DRAIN, 2 bits).
- The existing `sdp_bram` sub-module, instantiated with:
  - RAM_WIDTH=INST_WIDTH, RAM_DEPTH=DEPTH, HIGH_PERFORMANCE.
  - `wea` = accepted load.
  - `addra` = `prog_len[ADDR_WIDTH-1:0]`.
  - `addrb` = `pc`.
  - `enb` = 1, `regceb` = 1.
  - `rstb` = ~`rst_n`.
- Everything else is in this module: FSM, counters, and a RD_LAT-deep valid shift register.

## Test plan
- Load 4 words 0x1..0x4, then `start` with `loop_cnt`=0:
  - `prog_len`=4.
  - `inst_out` 0x1,0x2,0x3,0x4 on cycles 3–6 after `start`.
  - `done` on the 0x4 cycle.
- Same program, `loop_cnt`=2: 12 consecutive valid words repeating 0x1..0x4, `done` on the 12th.
- Same program, `stall` high for 3 cycles mid-RUN:
  - Exactly 2 in-flight words emerge, then a gap.
  - Sequence intact with no duplicates or skips.
  - Total 4 valid words.
- Load DEPTH+1 words:
  - `prog_len`=DEPTH, `load_err`=1.
  - Last word dropped; slot 0 unchanged.
  - `prog_clr` then sets `load_err`=0 and `prog_len`=0.
- Edge cases:
  - `start` with `prog_len`=0 gives `done` next cycle with no valid words.
  - `start` with `load_v` in the same cycle: the load wins and stays IDLE.
- Assert `rst_n`=0 asynchronously mid-RUN:
  - Outputs 0 immediately, with no `done`.
  - After release, `start` replays the preserved program once `prog_len` is reloaded.

Source files
------------

// File: rtl/imem_seq_pkg.sv
// Shared defaults and state encoding for the instruction memory sequencer.
package imem_seq_pkg;

    localparam int INST_WIDTH_DEF = 36;
    localparam int DEPTH_DEF      = 256;
    localparam int ADDR_WIDTH_DEF = $clog2(DEPTH_DEF);
    localparam int LOOP_WIDTH_DEF = 8;

    // Read latency of the BRAM with its output register enabled.
    localparam int RD_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/imem_seq_sdp_bram.sv
// Simple-dual-port block RAM, one clock, optional registered output.
// Contents have no reset so a program survives a controller reset.
module imem_seq_sdp_bram #(
    parameter int RAM_WIDTH        = 36,
    parameter int RAM_DEPTH        = 256,
    parameter bit HIGH_PERFORMANCE = 1'b1
) (
    input  logic                         clk,
    input  logic                         wea,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         enb,
    input  logic                         rstb,
    input  logic                         regceb,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    always_ff @(posedge clk) begin
        if (wea) begin
            mem[addra] <= dina;
        end
        if (enb) begin
            ram_data <= mem[addrb];
        end
    end

    generate
        if (HIGH_PERFORMANCE) begin : g_out_reg
            always_ff @(posedge clk) begin
                if (rstb) begin
                    doutb <= '0;
                end else if (regceb) begin
                    doutb <= ram_data;
                end
            end
        end else begin : g_no_out_reg
            assign doutb = ram_data;
        end
    endgenerate

endmodule

// File: rtl/imem_seq.sv
// Instruction memory and sequencer: loads a program word-by-word, then replays it
// on start for loop_cnt+1 passes with stall support and a completion pulse.
module imem_seq
    import imem_seq_pkg::*;
#(
    parameter int INST_WIDTH = INST_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LOOP_WIDTH = LOOP_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_v,
    input  logic [INST_WIDTH-1:0] load_inst,
    input  logic                  prog_clr,
    input  logic                  start,
    input  logic [LOOP_WIDTH-1:0] loop_cnt,
    input  logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic                  inst_out_v,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  load_err,
    output logic [1:0]            dbg_state
);

    // inst_out_v qualifies inst_out for exactly one cycle each; there is no ready.
    // stall is the only back-pressure and stops new reads, so up to RD_LAT words
    // already in flight still appear after stall is raised.

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [LOOP_WIDTH-1:0] pass_q, pass_d;
    logic [RD_LAT-1:0]     vpipe_q, vpipe_d;
    logic                  err_q, err_d;
    logic                  zdone_q, zdone_d;
    logic                  out_v_q;
    logic [INST_WIDTH-1:0] out_q;
    logic                  wr_en;
    logic                  rd_issue;
    logic                  last_pc;
    logic [INST_WIDTH-1:0] bram_dout;

    assign last_pc = (({1'b0, pc_q} + ONE_L) == len_q);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        pass_d   = pass_q;
        err_d    = err_q;
        zdone_d  = 1'b0;
        wr_en    = 1'b0;
        rd_issue = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (prog_clr) begin
                    len_d = '0;
                    err_d = 1'b0;
                end else if (load_v) begin
                    if (len_q < DEPTH_L) begin
                        wr_en = 1'b1;
                        len_d = len_q + ONE_L;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (start) begin
                    // An empty program completes immediately without leaving IDLE.
                    if (len_q == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        pc_d    = '0;
                        pass_d  = loop_cnt;
                    end
                end
            end

            ST_RUN: begin
                if (load_v) begin
                    err_d = 1'b1;
                end
                if (!stall) begin
                    rd_issue = 1'b1;
                    if (last_pc) begin
                        if (pass_q == '0) begin
                            state_d = ST_DRAIN;
                        end else begin
                            pass_d = pass_q - LOOP_WIDTH'(1);
                            pc_d   = '0;
                        end
                    end else begin
                        pc_d = pc_q + ADDR_WIDTH'(1);
                    end
                end
            end

            ST_DRAIN: begin
                if (load_v) begin
                    err_d = 1'b1;
                end
                // Empty pipeline means the final word now sits in the output register.
                if (vpipe_q == '0) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        vpipe_d = {vpipe_q[RD_LAT-2:0], rd_issue};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            pass_q  <= '0;
            vpipe_q <= '0;
            err_q   <= 1'b0;
            zdone_q <= 1'b0;
            out_v_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            pass_q  <= pass_d;
            vpipe_q <= vpipe_d;
            err_q   <= err_d;
            zdone_q <= zdone_d;
            out_v_q <= vpipe_q[RD_LAT-1];
            out_q   <= vpipe_q[RD_LAT-1] ? bram_dout : '0;
        end
    end

    imem_seq_sdp_bram #(
        .RAM_WIDTH        (INST_WIDTH),
        .RAM_DEPTH        (DEPTH),
        .HIGH_PERFORMANCE (1'b1)
    ) u_bram (
        .clk    (clk),
        .wea    (wr_en),
        .addra  (len_q[ADDR_WIDTH-1:0]),
        .dina   (load_inst),
        .enb    (1'b1),
        .rstb   (~rst_n),
        .regceb (1'b1),
        .addrb  (pc_q),
        .doutb  (bram_dout)
    );

    assign busy       = (state_q != ST_IDLE);
    assign done       = zdone_q | ((state_q == ST_DRAIN) && (vpipe_q == '0));
    assign inst_out_v = out_v_q;
    assign inst_out   = out_q;
    assign prog_len   = len_q;
    assign load_err   = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_seq.sv
// Directed bench for imem_seq: load, replay, multi-pass, stall, overflow,
// empty-program start, start/load collision and asynchronous reset mid-run.
module tb_imem_seq;
    import imem_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_v;
    logic [35:0] load_inst;
    logic        prog_clr;
    logic        start;
    logic [7:0]  loop_cnt;
    logic        stall;
    logic        busy;
    logic        done;
    logic        inst_out_v;
    logic [35:0] inst_out;
    logic [8:0]  prog_len;
    logic        load_err;
    logic [1:0]  dbg_state;

    imem_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_v     (load_v),
        .load_inst  (load_inst),
        .prog_clr   (prog_clr),
        .start      (start),
        .loop_cnt   (loop_cnt),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .inst_out_v (inst_out_v),
        .inst_out   (inst_out),
        .prog_len   (prog_len),
        .load_err   (load_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    logic [35:0] exp_q[$];
    logic [35:0] exp_w;
    logic [35:0] prog_mem [256];

    int   start_edge = 0;
    int   vcnt, dcnt, gaps, stall_v, first_rel, done_rel;
    logic prev_v, done_v, busy_at_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        vcnt = 0; dcnt = 0; gaps = 0; stall_v = 0;
        first_rel = -1; done_rel = -1;
        prev_v = 1'b0; done_v = 1'b0; busy_at_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (inst_out_v) begin
                if (vcnt == 0) first_rel = edge_n - start_edge;
                if (vcnt > 0 && !prev_v) gaps++;
                if (stall) stall_v++;
                vcnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_word", 64'(exp_q.size()), 64'(1));
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("inst", 64'(inst_out), 64'(exp_w));
                end
            end else begin
                chk("inst_gated", 64'(inst_out), 64'(0));
            end
            if (done) begin
                dcnt++;
                done_rel     = edge_n - start_edge;
                done_v       = inst_out_v;
                busy_at_done = busy;
            end
            prev_v = inst_out_v;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_word(input logic [35:0] w);
        load_v = 1'b1; load_inst = w;
        @(posedge clk); #1;
        load_v = 1'b0;
    endtask

    task automatic clear_prog();
        prog_clr = 1'b1;
        @(posedge clk); #1;
        prog_clr = 1'b0;
    endtask

    task automatic run_prog(input string tag, input int loops, input int len);
        exp_q.delete();
        for (int p = 0; p <= loops; p++)
            for (int i = 0; i < len; i++) exp_q.push_back(prog_mem[i]);
        clear_mon();
        start = 1'b1; loop_cnt = 8'(loops);
        @(posedge clk); #1;
        start_edge = edge_n; start = 1'b0;
        chk({tag, "_busy_rise"}, 64'(busy), 64'(1));
        for (int k = 0; k < 600 && dcnt == 0; k++) @(posedge clk);
        #1;
        chk({tag, "_done_cnt"}, 64'(dcnt), 64'(1));
        chk({tag, "_busy_at_done"}, 64'(busy_at_done), 64'(1));
        chk({tag, "_busy_fall"}, 64'(busy), 64'(0));
        chk({tag, "_left"}, 64'(exp_q.size()), 64'(0));
        chk({tag, "_nvalid"}, 64'(vcnt), 64'((loops + 1) * len));
        chk({tag, "_first"}, 64'(first_rel), 64'(3));
        chk({tag, "_done_v"}, 64'(done_v), 64'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; load_v = 1'b0; load_inst = '0; prog_clr = 1'b0;
        start = 1'b0; loop_cnt = '0; stall = 1'b0;
        clear_mon();
        #2;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_v", 64'(inst_out_v), 64'(0));
        chk("rst_len", 64'(prog_len), 64'(0));
        chk("rst_err", 64'(load_err), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // four-word program, one pass
        for (int i = 0; i < 4; i++) begin
            prog_mem[i] = 36'(i + 1);
            load_word(prog_mem[i]);
            chk("load_len", 64'(prog_len), 64'(i + 1));
        end
        run_prog("p1", 0, 4);
        chk("p1_done_rel", 64'(done_rel), 64'(6));
        chk("p1_gaps", 64'(gaps), 64'(0));

        // three passes
        run_prog("p3", 2, 4);
        chk("p3_done_rel", 64'(done_rel), 64'(14));
        chk("p3_gaps", 64'(gaps), 64'(0));

        // stall sampled on edges 3..5 after start
        fork
            run_prog("st", 0, 4);
            begin
                repeat (3) @(posedge clk);
                #1 stall = 1'b1;
                repeat (3) @(posedge clk);
                #1 stall = 1'b0;
            end
        join
        chk("st_inflight", 64'(stall_v), 64'(2));
        chk("st_gaps", 64'(gaps), 64'(1));
        chk("st_done_rel", 64'(done_rel), 64'(9));

        // start together with load_v: load wins
        clear_mon(); exp_q.delete();
        start = 1'b1; load_v = 1'b1; load_inst = 36'h5;
        @(posedge clk); #1;
        start = 1'b0; load_v = 1'b0;
        chk("sl_len", 64'(prog_len), 64'(5));
        chk("sl_busy", 64'(busy), 64'(0));
        repeat (6) @(posedge clk); #1;
        chk("sl_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("sl_nvalid", 64'(vcnt), 64'(0));
        chk("sl_done", 64'(dcnt), 64'(0));

        // clear together with load_v: clear wins
        prog_clr = 1'b1; load_v = 1'b1; load_inst = 36'h6;
        @(posedge clk); #1;
        prog_clr = 1'b0; load_v = 1'b0;
        chk("cl_len", 64'(prog_len), 64'(0));

        // start with empty program
        clear_mon();
        start = 1'b1; loop_cnt = 8'd3;
        @(posedge clk); #1;
        start_edge = edge_n; start = 1'b0;
        chk("z_busy", 64'(busy), 64'(0));
        repeat (3) @(posedge clk); #1;
        chk("z_done_cnt", 64'(dcnt), 64'(1));
        chk("z_done_rel", 64'(done_rel), 64'(0));
        chk("z_nvalid", 64'(vcnt), 64'(0));

        // overflow: DEPTH+1 loads
        for (int i = 0; i < 256; i++) begin
            prog_mem[i] = 36'h1000 + 36'(i);
            load_word(prog_mem[i]);
        end
        chk("of_err_pre", 64'(load_err), 64'(0));
        load_word(36'hDEAD);
        chk("of_len", 64'(prog_len), 64'(256));
        chk("of_err", 64'(load_err), 64'(1));
        run_prog("of", 0, 256);
        chk("of_done_rel", 64'(done_rel), 64'(258));
        clear_prog();
        chk("of_clr_len", 64'(prog_len), 64'(0));
        chk("of_clr_err", 64'(load_err), 64'(0));

        // reload, run, load while busy, then asynchronous reset mid-run
        for (int i = 0; i < 4; i++) begin
            prog_mem[i] = 36'(i + 1);
            load_word(prog_mem[i]);
        end
        exp_q.delete();
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 4; i++) exp_q.push_back(prog_mem[i]);
        clear_mon();
        start = 1'b1; loop_cnt = 8'd3;
        @(posedge clk); #1;
        start_edge = edge_n; start = 1'b0;
        load_v = 1'b1; load_inst = 36'hBAD;
        @(posedge clk); #1;
        load_v = 1'b0;
        chk("bz_err", 64'(load_err), 64'(1));
        chk("bz_len", 64'(prog_len), 64'(4));
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        chk("ar_pre_v", 64'(inst_out_v), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("ar_v", 64'(inst_out_v), 64'(0));
        chk("ar_inst", 64'(inst_out), 64'(0));
        chk("ar_busy", 64'(busy), 64'(0));
        chk("ar_done", 64'(done), 64'(0));
        chk("ar_len", 64'(prog_len), 64'(0));
        chk("ar_err", 64'(load_err), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        repeat (4) @(posedge clk); #1;
        chk("ar_no_done", 64'(dcnt), 64'(0));
        chk("ar_idle", 64'(dbg_state), 64'(ST_IDLE));
        for (int i = 0; i < 4; i++) load_word(prog_mem[i]);
        run_prog("ar", 0, 4);
        chk("ar_done_rel", 64'(done_rel), 64'(6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
